// File: rtl/instr_mem_boot.sv
// instr_mem_boot: instruction memory with valid/ready boot loader (BOOT) and 1-cycle fetch port (RUN)
//   load_valid_i/load_data_i/load_last_i/load_ready_o : chunk stream, packed little-endian into words from address 0
//   reload_i                                          : RUN -> BOOT, clears load pointer and load_err_o
//   fetch_valid_i/fetch_addr_i/fetch_ready_o          : fetch request, accepted only in RUN
//   rdata_o/rdata_valid_o/fetch_err_o                 : fetch result one cycle after acceptance
//   load_err_o : sticky overflow flag; running_o : high in RUN
module instr_mem_boot #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 2048,
  parameter int LOAD_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_valid_i,
  input  logic [LOAD_WIDTH-1:0] load_data_i,
  input  logic                  load_last_i,
  output logic                  load_ready_o,
  input  logic                  reload_i,
  input  logic                  fetch_valid_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  output logic                  fetch_ready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rdata_valid_o,
  output logic                  fetch_err_o,
  output logic                  load_err_o,
  output logic                  running_o
);
  localparam int CHUNKS = DATA_WIDTH / LOAD_WIDTH;
  localparam int CW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_P = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_C = CW'(CHUNKS - 1);
  typedef enum logic {BOOT, RUN} state_e;
  state_e state_q, state_d;
  logic load_ready_q, load_err_q, load_err_d, rdata_valid_q, fetch_err_q;
  logic [CW-1:0] cnt_q, cnt_d;
  // one bit wider than the address so the pointer can saturate at DEPTH
  logic [ADDR_WIDTH:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d, word, rdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic load_acc, wr, in_range, fetch_acc, fetch_in;
  assign load_acc = load_valid_i && load_ready_q && state_q == BOOT;
  assign wr = load_acc && (cnt_q == LAST_C || load_last_i);
  assign in_range = ptr_q < DEPTH_P;
  assign fetch_ready_o = state_q == RUN && !reload_i;
  assign fetch_acc = fetch_valid_i && fetch_ready_o;
  assign fetch_in = {1'b0, fetch_addr_i} < DEPTH_P;
  // buf_q is cleared after every write, so unfilled upper fields of a partial word are zero
  assign word = buf_q | (DATA_WIDTH'(load_data_i) << (LOAD_WIDTH * int'(cnt_q)));
  assign load_ready_o = load_ready_q;
  assign rdata_o = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign fetch_err_o = fetch_err_q;
  assign load_err_o = load_err_q;
  assign running_o = state_q == RUN;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    buf_d = buf_q;
    load_err_d = load_err_q;
    if (load_acc) begin
      buf_d = wr ? '0 : word;
      cnt_d = wr ? '0 : cnt_q + 1'b1;
      ptr_d = wr && in_range ? ptr_q + 1'b1 : ptr_q;
      load_err_d = load_err_q | (wr && !in_range);
      state_d = load_last_i ? RUN : state_q;
    end
    if (state_q == RUN && reload_i) begin
      state_d = BOOT;
      cnt_d = '0;
      ptr_d = '0;
      buf_d = '0;
      load_err_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= BOOT;
      load_ready_q <= 1'b0;
      cnt_q <= '0;
      ptr_q <= '0;
      buf_q <= '0;
      load_err_q <= 1'b0;
      rdata_q <= '0;
      rdata_valid_q <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      load_ready_q <= state_d == BOOT;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      buf_q <= buf_d;
      load_err_q <= load_err_d;
      rdata_valid_q <= fetch_acc;
      if (fetch_acc) begin
        rdata_q <= fetch_in ? mem[fetch_addr_i[IW-1:0]] : '0;
        fetch_err_q <= !fetch_in;
      end
    end
  end
  // storage is never reset; writes are gated off while reset is asserted
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr && in_range) mem[ptr_q[IW-1:0]] <= word;
  end
endmodule

// File: doc/instr_mem_boot.md
# instr_mem_boot

Parametrised instruction memory with a built-in boot loader. After reset, the block accepts a program as a stream of narrow chunks on a valid/ready load port. It assembles the chunks into words and writes them from address 0 upward. It then switches to run mode and serves one-cycle-latency instruction fetches to the core front end. It generalises the fixed 2048x32 instruction store with configurable geometry, a load FSM, fetch handshaking, range checking and in-field reload.

## Interface
- DATA_WIDTH, 32, instruction word width in bits.
- ADDR_WIDTH, 16, width of fetch_addr and of the internal load pointer.
- DEPTH, 2048, number of words; must satisfy DEPTH <= 2**ADDR_WIDTH.
- LOAD_WIDTH, 8, load chunk width; DATA_WIDTH must be an integer multiple (CHUNKS = DATA_WIDTH/LOAD_WIDTH).

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- load_valid  in  1  load chunk present.
- load_data  in  LOAD_WIDTH  load chunk.
- load_last  in  1  qualifies the final chunk of the program.
- load_ready  out  1  block accepts a chunk this cycle.
- reload  in  1  single-cycle request to return from RUN to BOOT.
- fetch_valid  in  1  fetch request.
- fetch_addr  in  ADDR_WIDTH  word address.
- fetch_ready  out  1  fetch accepted when high together with fetch_valid.
- rdata  out  DATA_WIDTH  fetched word.
- rdata_valid  out  1  one-cycle pulse: rdata and fetch_err are valid.
- fetch_err  out  1  the fetch completing this cycle was out of range.
- load_err  out  1  sticky flag: the load overflowed DEPTH.
- running  out  1  high in RUN.

## Operation
- FSM states: BOOT and RUN. Reset enters BOOT.
- BOOT behaviour:
  - load_ready = 1 (registered; see Timing). fetch_ready = 0.
  - A chunk is accepted on load_valid && load_ready.
  - Chunks pack little-endian: the first chunk goes to bits [LOAD_WIDTH-1:0], the next chunk to the next field up.
  - When CHUNKS chunks have been accepted, the word is written to mem[ptr], ptr increments and the chunk counter clears.
- load_last on an accepted chunk:
  - Any partial word is written with its unfilled upper fields zero.
  - The FSM moves to RUN.
  - A load of zero chunks is impossible: the FSM leaves BOOT only via load_last.
- Overflow: a word write with ptr >= DEPTH is discarded and sets load_err. load_err clears only on reset or on reload. ptr saturates at DEPTH and does not wrap.
- RUN behaviour:
  - load_ready = 0; load_valid is ignored.
  - fetch_ready = !reload.
  - An accepted fetch with fetch_addr < DEPTH returns mem[fetch_addr] with fetch_err = 0.
  - An accepted fetch with fetch_addr >= DEPTH returns rdata = 0 with fetch_err = 1.
- reload in RUN:
  - Next state is BOOT; ptr, the chunk counter and load_err clear.
  - Memory contents are retained. Words the new load does not overwrite keep their old values.
  - reload in BOOT is ignored.
- Memory contents are never reset or initialised by the block.

## Timing
- Values held while rst_n is low:
  - state BOOT; load_ready 0; rdata 0; rdata_valid 0.
  - fetch_err 0; load_err 0; running 0; ptr 0; chunk counter 0.
- load_ready rises on the first edge where rst_n is sampled high. The first chunk can be accepted in the cycle after that edge.
- A word write occurs on the same edge that accepts the completing chunk. There is no write-to-read hazard: fetches are only accepted in RUN.
- load_last edge: running = 1 and load_ready = 0 from the next cycle. The first fetch can be accepted in that cycle.
- Fetch latency is exactly 1 cycle:
  - A fetch accepted at edge N produces rdata, fetch_err and rdata_valid = 1 after edge N.
  - Back-to-back fetches give one result per cycle.
  - rdata holds its last value when rdata_valid = 0.
- reload and fetch_valid in the same cycle: the fetch is not accepted; reload wins. A fetch accepted in the preceding cycle still completes normally.
- Reset mid-load or mid-fetch: every register returns to its reset value on that edge, and an in-flight rdata_valid is suppressed.

## Test plan
- Defaults. Reset, then load 8 chunks 0x11..0x88 with load_last on the 8th -> mem[0]=0x44332211, mem[1]=0x88776655. running=1 the cycle after the last chunk. Fetching addr 1 gives rdata=0x88776655 one cycle later.
- Partial word. Load 0xAA, 0xBB, then 0xCC with load_last -> mem[0]=0x00CCBBAA; load_err=0.
- Streaming fetch. fetch_valid held high for addrs 0,1,0,1 -> rdata_valid high for 4 consecutive cycles with the matching words; fetch_err=0.
- Out-of-range fetch. fetch_addr=2048 -> rdata=0, fetch_err=1, rdata_valid=1. The next in-range fetch clears fetch_err.
- Overflow. Use DEPTH=4 and load 6 words -> words 0..3 are stored, load_err=1, mem[0] is unchanged by the 5th and 6th words.
- Reload. In RUN, assert reload together with fetch_valid -> that fetch is not accepted and load_ready=1 next cycle. Loading one word 0xDEADBEEF gives mem[0]=0xDEADBEEF while mem[1] keeps its old value. A separate check: rst_n low during a partial load -> the chunk counter and ptr are 0 afterwards.
